// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin writeback arbiter for four units feeding one staged writeback port
module wb_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int REGBIT     = 6
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  flush,
  input  logic                  alu_wb_valid,
  input  logic [REGBIT-1:0]     alu_wb_dst,
  input  logic [DATA_WIDTH-1:0] alu_wb_data,
  input  logic [3:0]            alu_wb_byte_wen,
  output logic                  alu_wb_ready,
  input  logic                  bru_wb_valid,
  input  logic [REGBIT-1:0]     bru_wb_dst,
  input  logic [DATA_WIDTH-1:0] bru_wb_data,
  input  logic [3:0]            bru_wb_byte_wen,
  output logic                  bru_wb_ready,
  input  logic                  lsu_wb_valid,
  input  logic [REGBIT-1:0]     lsu_wb_dst,
  input  logic [DATA_WIDTH-1:0] lsu_wb_data,
  input  logic [3:0]            lsu_wb_byte_wen,
  output logic                  lsu_wb_ready,
  input  logic                  mdu_wb_valid,
  input  logic [REGBIT-1:0]     mdu_wb_dst,
  input  logic [DATA_WIDTH-1:0] mdu_wb_data,
  input  logic [3:0]            mdu_wb_byte_wen,
  output logic                  mdu_wb_ready,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [REGBIT-1:0]     wb_dst,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic [3:0]            wb_byte_wen,
  output logic [2:0]            wb_fu,
  output logic [31:0]           wb_count
);
  logic                  r_valid;
  logic [REGBIT-1:0]     r_dst;
  logic [DATA_WIDTH-1:0] r_data;
  logic [3:0]            r_wen;
  logic [2:0]            r_fu;
  logic [31:0]           r_count;
  logic [1:0]            r_last;
  logic [3:0]            w_req;
  logic                  w_en;
  logic                  w_any;
  logic [1:0]            w_idx;
  logic [3:0]            w_gnt;
  logic                  w_consume;
  logic [REGBIT-1:0]     w_dst;
  logic [DATA_WIDTH-1:0] w_data;
  logic [3:0]            w_wen;

  // Grants depend only on valids, the slot state, flush and reset, never on request payloads.
  assign w_req     = {mdu_wb_valid, lsu_wb_valid, bru_wb_valid, alu_wb_valid};
  assign w_en      = (!r_valid || wb_ready) && !flush && resetn;
  assign w_consume = r_valid && wb_ready;
  assign w_gnt     = w_any ? 4'b0001 << w_idx : 4'b0000;
  assign {mdu_wb_ready, lsu_wb_ready, bru_wb_ready, alu_wb_ready} = w_gnt;

  // Round-robin search starting just after the last grant; the last grantee is checked last.
  always_comb begin
    w_any = 1'b0;
    w_idx = r_last;
    for (int k = 1; k <= 4; k++) begin
      if (!w_any && w_req[r_last + 2'(k)]) begin
        w_any = 1'b1;
        w_idx = r_last + 2'(k);
      end
    end
    w_any = w_any && w_en;
  end

  // Payload mux for the granted unit.
  always_comb begin
    w_dst  = w_idx == 2'd0 ? alu_wb_dst  : w_idx == 2'd1 ? bru_wb_dst  : w_idx == 2'd2 ? lsu_wb_dst  : mdu_wb_dst;
    w_data = w_idx == 2'd0 ? alu_wb_data : w_idx == 2'd1 ? bru_wb_data : w_idx == 2'd2 ? lsu_wb_data : mdu_wb_data;
    w_wen  = w_idx == 2'd0 ? alu_wb_byte_wen : w_idx == 2'd1 ? bru_wb_byte_wen : w_idx == 2'd2 ? lsu_wb_byte_wen : mdu_wb_byte_wen;
  end

  // Stage register, consume counter and last-grant pointer; writes to GPR zero keep the slot but drop the enables.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_valid <= 1'b0;
      r_dst   <= '0;
      r_data  <= '0;
      r_wen   <= 4'b0000;
      r_fu    <= 3'd0;
      r_count <= 32'd0;
      r_last  <= 2'd3;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_fu    <= 3'd0;
    end else begin
      if (w_consume) r_count <= r_count + 32'd1;
      if (w_any) begin
        r_valid <= 1'b1;
        r_dst   <= w_dst;
        r_data  <= w_data;
        r_wen   <= w_dst == '0 ? 4'b0000 : w_wen;
        r_fu    <= {1'b0, w_idx} + 3'd1;
        r_last  <= w_idx;
      end else if (w_consume) begin
        r_valid <= 1'b0;
        r_fu    <= 3'd0;
      end
    end
  end

  assign wb_valid    = r_valid;
  assign wb_dst      = r_dst;
  assign wb_data     = r_data;
  assign wb_byte_wen = r_wen;
  assign wb_fu       = r_fu;
  assign wb_count    = r_count;
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed checks of grant order, staging, backpressure, zero-dst, flush and reset
module tb_wb_arbiter;
  logic        clk = 1'b0;
  logic        resetn, flush;
  logic        alu_v, bru_v, lsu_v, mdu_v;
  logic [5:0]  alu_d, bru_d, lsu_d, mdu_d;
  logic [31:0] alu_x, bru_x, lsu_x, mdu_x;
  logic [3:0]  alu_w, bru_w, lsu_w, mdu_w;
  logic        alu_r, bru_r, lsu_r, mdu_r;
  logic        wb_valid, wb_ready;
  logic [5:0]  wb_dst;
  logic [31:0] wb_data;
  logic [3:0]  wb_byte_wen;
  logic [2:0]  wb_fu;
  logic [31:0] wb_count;
  int          n_assert = 0;
  int          n_fail = 0;

  wb_arbiter dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .alu_wb_valid(alu_v), .alu_wb_dst(alu_d), .alu_wb_data(alu_x), .alu_wb_byte_wen(alu_w), .alu_wb_ready(alu_r),
    .bru_wb_valid(bru_v), .bru_wb_dst(bru_d), .bru_wb_data(bru_x), .bru_wb_byte_wen(bru_w), .bru_wb_ready(bru_r),
    .lsu_wb_valid(lsu_v), .lsu_wb_dst(lsu_d), .lsu_wb_data(lsu_x), .lsu_wb_byte_wen(lsu_w), .lsu_wb_ready(lsu_r),
    .mdu_wb_valid(mdu_v), .mdu_wb_dst(mdu_d), .mdu_wb_data(mdu_x), .mdu_wb_byte_wen(mdu_w), .mdu_wb_ready(mdu_r),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_dst(wb_dst), .wb_data(wb_data),
    .wb_byte_wen(wb_byte_wen), .wb_fu(wb_fu), .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rdy();
    return {28'd0, mdu_r, lsu_r, bru_r, alu_r};
  endfunction

  initial begin
    resetn = 1'b0; flush = 1'b0; wb_ready = 1'b1;
    {alu_v, bru_v, lsu_v, mdu_v} = 4'b0000;
    alu_d = 6'd0; bru_d = 6'd0; lsu_d = 6'd0; mdu_d = 6'd0;
    alu_x = 32'd0; bru_x = 32'd0; lsu_x = 32'd0; mdu_x = 32'd0;
    alu_w = 4'h0; bru_w = 4'h0; lsu_w = 4'h0; mdu_w = 4'h0;
    alu_v = 1'b1; bru_v = 1'b1;
    step(); step();
    chk("rst_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_fu", {29'd0, wb_fu}, 32'd0);
    chk("rst_dst", {26'd0, wb_dst}, 32'd0);
    chk("rst_data", wb_data, 32'd0);
    chk("rst_wen", {28'd0, wb_byte_wen}, 32'd0);
    chk("rst_count", wb_count, 32'd0);
    chk("rst_ready", rdy(), 32'd0);
    bru_v = 1'b0;
    // single-unit transfer straight out of reset
    resetn = 1'b1;
    alu_d = 6'd5; alu_x = 32'h12345678; alu_w = 4'hF;
    #1 chk("single_ready", rdy(), 32'h1);
    step();
    alu_v = 1'b0;
    chk("single_valid", {31'd0, wb_valid}, 32'd1);
    chk("single_dst", {26'd0, wb_dst}, 32'd5);
    chk("single_data", wb_data, 32'h12345678);
    chk("single_fu", {29'd0, wb_fu}, 32'd1);
    chk("single_wen", {28'd0, wb_byte_wen}, 32'hF);
    chk("single_cnt0", wb_count, 32'd0);
    step();
    chk("single_cnt1", wb_count, 32'd1);
    chk("single_drain", {31'd0, wb_valid}, 32'd0);
    chk("single_fu0", {29'd0, wb_fu}, 32'd0);
    // round-robin with all four valid, starting fresh from reset
    resetn = 1'b0;
    #1 resetn = 1'b1;
    {alu_v, bru_v, lsu_v, mdu_v} = 4'b1111;
    alu_d = 6'd1; bru_d = 6'd2; lsu_d = 6'd3; mdu_d = 6'd4;
    alu_w = 4'h1; bru_w = 4'h3; lsu_w = 4'h7; mdu_w = 4'hF;
    for (int i = 0; i < 8; i++) begin
      #1 chk($sformatf("rr_gnt%0d", i), rdy(), 32'h1 << (i % 4));
      step();
      chk($sformatf("rr_fu%0d", i), {29'd0, wb_fu}, 32'(i % 4 + 1));
      chk($sformatf("rr_dst%0d", i), {26'd0, wb_dst}, 32'(i % 4 + 1));
    end
    {alu_v, bru_v, lsu_v, mdu_v} = 4'b0000;
    chk("rr_cnt7", wb_count, 32'd7);
    step();
    chk("rr_cnt8", wb_count, 32'd8);
    // backpressure: stage holds lsu dst 7, pointer on lsu
    lsu_v = 1'b1; lsu_d = 6'd7; lsu_x = 32'hCAFE0007;
    step();
    lsu_v = 1'b0; alu_v = 1'b1; mdu_v = 1'b1; mdu_d = 6'd9; mdu_x = 32'h0000BEEF; wb_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("bp_ready%0d", i), rdy(), 32'h0);
      chk($sformatf("bp_dst%0d", i), {26'd0, wb_dst}, 32'd7);
      chk($sformatf("bp_data%0d", i), wb_data, 32'hCAFE0007);
      chk($sformatf("bp_fu%0d", i), {29'd0, wb_fu}, 32'd3);
      chk($sformatf("bp_valid%0d", i), {31'd0, wb_valid}, 32'd1);
      step();
    end
    chk("bp_cnt_hold", wb_count, 32'd8);
    wb_ready = 1'b1;
    #1 chk("bp_mdu_gnt", rdy(), 32'h8);
    step();
    {alu_v, bru_v, lsu_v, mdu_v} = 4'b0000;
    chk("bp_b2b_valid", {31'd0, wb_valid}, 32'd1);
    chk("bp_b2b_fu", {29'd0, wb_fu}, 32'd4);
    chk("bp_b2b_data", wb_data, 32'h0000BEEF);
    chk("bp_cnt9", wb_count, 32'd9);
    step();
    chk("bp_cnt10", wb_count, 32'd10);
    // zero destination keeps the slot but drops the enables
    bru_v = 1'b1; bru_d = 6'd0; bru_w = 4'hF; bru_x = 32'hAA;
    #1 chk("z_gnt", rdy(), 32'h2);
    step();
    bru_v = 1'b0;
    chk("z_valid", {31'd0, wb_valid}, 32'd1);
    chk("z_wen", {28'd0, wb_byte_wen}, 32'd0);
    chk("z_fu", {29'd0, wb_fu}, 32'd2);
    step();
    chk("z_cnt", wb_count, 32'd11);
    // flush with a staged write being consumed and alu requesting
    lsu_v = 1'b1; lsu_d = 6'd3;
    step();
    lsu_v = 1'b0; alu_v = 1'b1; alu_d = 6'd6; alu_x = 32'h66; flush = 1'b1;
    #1 chk("fl_noready", rdy(), 32'h0);
    step();
    flush = 1'b0;
    chk("fl_valid", {31'd0, wb_valid}, 32'd0);
    chk("fl_fu", {29'd0, wb_fu}, 32'd0);
    chk("fl_cnt", wb_count, 32'd11);
    #1 chk("fl_alu_gnt", rdy(), 32'h1);
    step();
    alu_v = 1'b0;
    chk("fl_alu_fu", {29'd0, wb_fu}, 32'd1);
    chk("fl_alu_dst", {26'd0, wb_dst}, 32'd6);
    step();
    chk("fl_cnt12", wb_count, 32'd12);
    // asynchronous reset while a write is staged
    bru_v = 1'b1; bru_d = 6'd2; wb_ready = 1'b0;
    step();
    {alu_v, bru_v, lsu_v, mdu_v} = 4'b1111;
    chk("mr_pre_valid", {31'd0, wb_valid}, 32'd1);
    #2 resetn = 1'b0;
    #1 chk("mr_valid", {31'd0, wb_valid}, 32'd0);
    chk("mr_fu", {29'd0, wb_fu}, 32'd0);
    chk("mr_cnt", wb_count, 32'd0);
    chk("mr_ready", rdy(), 32'h0);
    step();
    resetn = 1'b1; wb_ready = 1'b1;
    #1 chk("mr_alu_first", rdy(), 32'h1);
    step();
    chk("mr_alu_fu", {29'd0, wb_fu}, 32'd1);
    {alu_v, bru_v, lsu_v, mdu_v} = 4'b0000;
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, datapath width.
REQ-002 SHALL have parameter REGBIT, default 6, destination register index width (GPR plus HI/LO codes).
REQ-003 SHALL have ports:
- clk  input  1  clock; one clock, all state on rising edge.
- resetn  input  1  reset; asynchronous, active-low.
- flush  input  1  discard staged and incoming writebacks.
REQ-004 SHALL have, for each X in {alu, bru, lsu, mdu}, these request ports:
- X_wb_valid  input  1  X holds a result.
- X_wb_dst  input  REGBIT  destination register.
- X_wb_data  input  DATA_WIDTH  result.
- X_wb_byte_wen  input  4  byte enables.
- X_wb_ready  output  1  result accepted this cycle.
REQ-005 SHALL have these writeback-port signals:
- wb_valid  output  1  staged write present.
- wb_ready  input  1  consumer accepts staged write.
- wb_dst  output  REGBIT  staged destination.
- wb_data  output  DATA_WIDTH  staged data.
- wb_byte_wen  output  4  staged byte enables.
- wb_fu  output  3  source unit: 1=alu, 2=bru, 3=lsu, 4=mdu, 0=none.
- wb_count  output  32  count of writes consumed.

Function
REQ-006 SHALL hold one output stage register (the stage); latency from request acceptance to wb_valid is exactly 1 cycle.
REQ-007 SHALL define slot_free = !wb_valid | wb_ready.
REQ-008 SHALL grant at most one requester per cycle, and only when slot_free & !flush.
REQ-009 SHALL assert X_wb_ready only for the granted requester; acceptance occurs when X_wb_valid & X_wb_ready.
REQ-010 SHALL keep X_wb_ready combinationally independent of X_wb_data and X_wb_byte_wen.
REQ-011 SHALL arbitrate round-robin over the order alu(0), bru(1), lsu(2), mdu(3) using a 2-bit last-grant pointer.
REQ-012 SHALL search from last+1, wrapping from 3 to 0.
REQ-013 SHALL update the pointer only on acceptance.
REQ-014 SHALL, on acceptance, load the stage with the requester's dst, data, byte_wen and fu code, and set wb_valid=1.
REQ-015 SHALL force the staged wb_byte_wen to 4'b0000 when the accepted dst is 0 (GPR zero); such a write still occupies the stage and is still counted.
REQ-016 SHALL, when wb_valid & wb_ready and no new acceptance occurs, clear wb_valid and set wb_fu to 0.
REQ-017 SHALL treat wb_valid & wb_ready together with a new acceptance in the same cycle as back-to-back: the stage reloads and wb_valid stays 1.
REQ-018 SHALL hold all stage outputs stable while wb_valid & !wb_ready.
REQ-019 SHALL grant nothing while wb_valid & !wb_ready.
REQ-020 SHALL increment wb_count by 1 on each cycle with wb_valid & wb_ready; the count wraps from 0xFFFFFFFF to 0.
REQ-021 SHALL, on flush:
- clear wb_valid and wb_fu;
- issue no grant that cycle;
- leave the pointer unchanged;
- not increment wb_count, even if wb_ready=1 that cycle.
REQ-022 SHALL not require requesters to hold valid; a dropped valid before acceptance is legal and loses nothing inside the block.
REQ-023 SHALL grant fairly: with all four requesters continuously valid and wb_ready=1, grants rotate alu, bru, lsu, mdu, alu... with one acceptance every cycle.

Reset
REQ-024 SHALL, while resetn=0 (asynchronously), force:
- wb_valid=0, wb_fu=0, wb_dst=0, wb_data=0, wb_byte_wen=0;
- wb_count=0;
- last-grant pointer=3, so alu has first priority after reset.
REQ-025 SHALL drive all X_wb_ready=0 while resetn=0.
REQ-026 SHALL discard any in-flight stage content on reset assertion mid-operation.
REQ-027 SHALL accept the first request on the first rising edge after resetn deasserts.

Verification
REQ-028 SHALL pass the single-unit test: after reset, alu_wb_valid=1, dst=5, data=0x12345678, wen=4'hF, wb_ready=1 -> alu_wb_ready=1 that cycle; next cycle wb_valid=1, wb_dst=5, wb_data=0x12345678, wb_fu=1; wb_count=1 one cycle later.
REQ-029 SHALL pass the round-robin test: all four valid for 8 cycles, wb_ready=1 -> acceptance order alu,bru,lsu,mdu,alu,bru,lsu,mdu; wb_count=8 after the last consume.
REQ-030 SHALL pass the backpressure test: stage holds lsu dst=7, wb_ready=0 for 3 cycles with alu and mdu valid -> all X_wb_ready=0 and stage unchanged; on wb_ready=1, mdu is granted (pointer was lsu=2) with wb_valid continuous.
REQ-031 SHALL pass the zero-dst test: bru writes dst=0, wen=4'hF -> staged wb_byte_wen=4'b0000, wb_fu=2, wb_count still increments.
REQ-032 SHALL pass the flush test: flush=1 with wb_valid=1, wb_ready=1 and alu valid -> next cycle wb_valid=0, alu not accepted, wb_count unchanged; the following cycle alu is accepted.
REQ-033 SHALL pass the reset-mid-operation test: resetn driven low between edges while wb_valid=1 -> wb_valid=0 immediately; after release, alu wins over simultaneous bru/lsu/mdu requests.
